// File: rtl/acc_seq.sv
// Job sequencer for the accumulator/output stage: frames one convolution job as a
// concat burst (start, per output: accumulate x acc_len then output, end).
module acc_seq #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] acc_len,
  input  logic [CNT_W-1:0] out_num,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic [2:0]       sig_o,
  output logic [DW-1:0]    data_o,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StCstart,
    StAcc,
    StEmit,
    StCend,
    StDone
  } state_e;

  localparam logic [2:0] CmdNop    = 3'b000;
  localparam logic [2:0] CmdAcc    = 3'b001;
  localparam logic [2:0] CmdOut    = 3'b010;
  localparam logic [2:0] CmdCstart = 3'b011;
  localparam logic [2:0] CmdCend   = 3'b100;

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] acc_len_q;
  logic [CNT_W-1:0] out_num_q;
  logic [CNT_W-1:0] beat_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic [2:0]       sig_q;
  logic [DW-1:0]    data_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;

  logic abort_hit;
  logic beat_fire;
  logic last_beat;
  logic more_out;

  // Abort only acts while the burst body is in flight; CEND/DONE run to completion.
  assign abort_hit = abort &&
                     ((state_q == StCstart) || (state_q == StAcc) || (state_q == StEmit));

  assign in_ready  = (state_q == StAcc) && !abort;
  assign beat_fire = in_ready && in_valid;

  // Latched lengths are non-zero whenever these are consulted.
  assign last_beat = (beat_q == (acc_len_q - One));
  assign more_out  = (out_cnt_q < (out_num_q - One));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      acc_len_q <= '0;
      out_num_q <= '0;
      beat_q    <= '0;
      out_cnt_q <= '0;
      sig_q     <= CmdNop;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      sig_q  <= CmdNop;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            acc_len_q <= acc_len;
            out_num_q <= out_num;
            out_cnt_q <= '0;
            aborted_q <= 1'b0;
            beat_q    <= '0;
            busy_q    <= 1'b1;
            if ((acc_len == '0) || (out_num == '0)) begin
              state_q <= StDone;
            end else begin
              state_q <= StCstart;
            end
          end
        end
        StCstart: begin
          if (abort_hit) begin
            aborted_q <= 1'b1;
            state_q   <= StCend;
          end else begin
            sig_q   <= CmdCstart;
            beat_q  <= '0;
            state_q <= StAcc;
          end
        end
        StAcc: begin
          if (abort_hit) begin
            aborted_q <= 1'b1;
            state_q   <= StCend;
          end else if (beat_fire) begin
            sig_q  <= CmdAcc;
            data_q <= in_data;
            if (last_beat) begin
              beat_q  <= '0;
              state_q <= StEmit;
            end else begin
              beat_q <= beat_q + One;
            end
          end
        end
        StEmit: begin
          if (abort_hit) begin
            aborted_q <= 1'b1;
            state_q   <= StCend;
          end else begin
            sig_q     <= CmdOut;
            out_cnt_q <= out_cnt_q + One;
            beat_q    <= '0;
            state_q   <= more_out ? StAcc : StCend;
          end
        end
        StCend: begin
          sig_q   <= CmdCend;
          state_q <= StDone;
        end
        StDone: begin
          // done and the busy drop become visible together as IDLE is re-entered.
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sig_o   = sig_q;
  assign data_o  = data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign out_cnt = out_cnt_q;

endmodule

// File: tb/tb_acc_seq.sv
// Scoreboard bench for acc_seq: expected command streams are queued per job and
// compared against the non-nop commands seen on sig_o/data_o.
module tb_acc_seq;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] acc_len = '0;
  logic [CW-1:0] out_num = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [2:0]    sig_o;
  logic [DW-1:0] data_o;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [CW-1:0] out_cnt;

  always #5 clk = ~clk;

  acc_seq #(.DW(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .acc_len  (acc_len),
    .out_num  (out_num),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .sig_o    (sig_o),
    .data_o   (data_o),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .out_cnt  (out_cnt)
  );

  typedef logic [DW+2:0] cmd_t;

  cmd_t exp_q[$];
  cmd_t obs_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   rdy_bad = 0;
  int   feed = 1;
  bit   seen_done, done_aborted, done_busy;

  // Record every non-nop command; data only matters on accumulate.
  always @(negedge clk) begin
    if (rst && sig_o != 3'b000)
      obs_q.push_back({sig_o, (sig_o == 3'b001) ? data_o : {DW{1'b0}}});
    if (done) done_cnt <= done_cnt + 1;
    if (in_ready && !busy) rdy_bad <= rdy_bad + 1;
  end

  function automatic cmd_t mk(input logic [2:0] s, input int d);
    return {s, DW'(d)};
  endfunction

  task automatic push_job(input int len, input int num, input int first);
    int d = first;
    exp_q.push_back(mk(3'b011, 0));
    for (int o = 0; o < num; o++) begin
      for (int b = 0; b < len; b++) begin
        exp_q.push_back(mk(3'b001, d));
        d++;
      end
      exp_q.push_back(mk(3'b010, 0));
    end
    exp_q.push_back(mk(3'b100, 0));
  endtask

  task automatic step(input bit toggle);
    bit fire;
    @(negedge clk);
    fire = in_valid && in_ready;
    seen_done = done;
    done_aborted = aborted;
    done_busy = busy;
    @(posedge clk);
    #1;
    if (fire) feed++;
    in_data = DW'(feed);
    if (toggle) in_valid = ~in_valid;
  endtask

  task automatic start_job(input int len, input int num, input bit with_abort);
    @(posedge clk);
    #1;
    acc_len = CW'(len);
    out_num = CW'(num);
    start = 1'b1;
    abort = with_abort;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, input int budget, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < budget) begin
      step(toggle);
      n++;
      if (seen_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sig_o, data_o, busy, done, aborted, out_cnt, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state: sig=%b data=%h busy=%b done=%b ab=%b cnt=%0d rdy=%b, want all 0",
               sig_o, data_o, busy, done, aborted, out_cnt, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int n; bit ok; int d0; cmd_t e, g;
    exp_q.delete(); obs_q.delete();
    feed = 1; in_data = 1; in_valid = 1'b1;
    push_job(3, 2, 1);
    d0 = done_cnt;
    start_job(3, 2, 1'b0);
    wait_done(1'b0, 60, n, ok);
    step(1'b0);
    checks++;
    if (!ok || n != 12) begin
      errors++; $display("FAIL basic_latency: got ok=%b n=%0d, want ok=1 n=12", ok, n);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL basic_cmd: got none, want %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL basic_cmd: got %h, want %h", g, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL basic_extra: got %0d extra cmds, want 0", obs_q.size());
    end
    checks++;
    if (done_cnt - d0 != 1 || done_aborted !== 1'b0 || done_busy !== 1'b0 || out_cnt !== 16'd2) begin
      errors++;
      $display("FAIL basic_status: got done=%0d ab=%b busy=%b cnt=%0d, want 1 0 0 2",
               done_cnt - d0, done_aborted, done_busy, out_cnt);
    end
  endtask

  task automatic test_toggle();
    int n; bit ok; int d0; int r0; cmd_t e, g;
    exp_q.delete(); obs_q.delete();
    feed = 1; in_data = 1; in_valid = 1'b1;
    push_job(3, 2, 1);
    d0 = done_cnt; r0 = rdy_bad;
    start_job(3, 2, 1'b0);
    wait_done(1'b1, 80, n, ok);
    step(1'b0);
    in_valid = 1'b0;
    checks++;
    if (!ok || n <= 12) begin
      errors++; $display("FAIL toggle_latency: got ok=%b n=%0d, want ok=1 n>12", ok, n);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL toggle_cmd: got none, want %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL toggle_cmd: got %h, want %h", g, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0 || feed != 7 || rdy_bad != r0) begin
      errors++;
      $display("FAIL toggle_stream: got extra=%0d feed=%0d rdy_bad=%0d, want 0 7 %0d",
               obs_q.size(), feed, rdy_bad, r0);
    end
    checks++;
    if (done_cnt - d0 != 1 || out_cnt !== 16'd2) begin
      errors++; $display("FAIL toggle_status: got done=%0d cnt=%0d, want 1 2", done_cnt - d0, out_cnt);
    end
  endtask

  task automatic test_zero_len();
    int n; bit ok; int d0;
    exp_q.delete(); obs_q.delete();
    feed = 1; in_data = 1; in_valid = 1'b1;
    d0 = done_cnt;
    start_job(0, 5, 1'b0);
    wait_done(1'b0, 20, n, ok);
    step(1'b0);
    checks++;
    if (!ok || n != 2) begin
      errors++; $display("FAIL zero_latency: got ok=%b n=%0d, want ok=1 n=2", ok, n);
    end
    checks++;
    if (obs_q.size() != 0 || feed != 1) begin
      errors++; $display("FAIL zero_cmds: got cmds=%0d feed=%0d, want 0 1", obs_q.size(), feed);
    end
    checks++;
    if (done_cnt - d0 != 1 || out_cnt !== 16'd0 || done_aborted !== 1'b0) begin
      errors++; $display("FAIL zero_status: got done=%0d cnt=%0d ab=%b, want 1 0 0",
                         done_cnt - d0, out_cnt, done_aborted);
    end
  endtask

  task automatic test_abort();
    int n; bit ok; int d0; cmd_t e, g;
    exp_q.delete(); obs_q.delete();
    feed = 1; in_data = 1; in_valid = 1'b1;
    exp_q.push_back(mk(3'b011, 0));
    for (int i = 1; i <= 4; i++) exp_q.push_back(mk(3'b001, i));
    exp_q.push_back(mk(3'b010, 0));
    exp_q.push_back(mk(3'b001, 5));
    exp_q.push_back(mk(3'b100, 0));
    d0 = done_cnt;
    start_job(4, 3, 1'b0);
    for (int i = 0; i < 40 && !(feed == 6 && in_ready); i++) step(1'b0);
    abort = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || feed != 6) begin
      errors++; $display("FAIL abort_ready: got rdy=%b feed=%0d, want 0 6", in_ready, feed);
    end
    step(1'b0);
    abort = 1'b0;
    wait_done(1'b0, 30, n, ok);
    step(1'b0);
    checks++;
    if (!ok || feed != 6) begin
      errors++; $display("FAIL abort_done: got ok=%b feed=%0d, want 1 6", ok, feed);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL abort_cmd: got none, want %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL abort_cmd: got %h, want %h", g, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL abort_extra: got %0d extra cmds, want 0", obs_q.size());
    end
    checks++;
    if (done_cnt - d0 != 1 || done_aborted !== 1'b1 || out_cnt !== 16'd1) begin
      errors++; $display("FAIL abort_status: got done=%0d ab=%b cnt=%0d, want 1 1 1",
                         done_cnt - d0, done_aborted, out_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    int n; bit ok; int d0; cmd_t e, g;
    exp_q.delete(); obs_q.delete();
    feed = 1; in_data = 1; in_valid = 1'b1;
    push_job(2, 2, 1);
    d0 = done_cnt;
    // abort alongside the accepted start must be ignored
    start_job(2, 2, 1'b1);
    step(1'b0);
    step(1'b0);
    acc_len = 16'd5;
    out_num = 16'd1;
    start = 1'b1;
    step(1'b0);
    start = 1'b0;
    wait_done(1'b0, 60, n, ok);
    step(1'b0);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_done: got timeout, want done"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL busy_cmd: got none, want %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL busy_cmd: got %h, want %h", g, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0 || done_cnt - d0 != 1 || out_cnt !== 16'd2 || done_aborted !== 1'b0) begin
      errors++;
      $display("FAIL busy_status: got extra=%0d done=%0d cnt=%0d ab=%b, want 0 1 2 0",
               obs_q.size(), done_cnt - d0, out_cnt, done_aborted);
    end
  endtask

  task automatic test_reset_mid_job();
    int n; bit ok; cmd_t e, g;
    exp_q.delete(); obs_q.delete();
    feed = 1; in_data = 1; in_valid = 1'b1;
    start_job(3, 2, 1'b0);
    repeat (3) step(1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (sig_o !== 3'b000 || busy !== 1'b0 || in_ready !== 1'b0 || out_cnt !== 16'd0 ||
        data_o !== '0) begin
      errors++; $display("FAIL midrst_state: got sig=%b busy=%b rdy=%b cnt=%0d data=%h, want 0s",
                         sig_o, busy, in_ready, out_cnt, data_o);
    end
    exp_q.delete(); obs_q.delete();
    @(negedge clk);
    rst = 1'b1;
    feed = 1; in_data = 1;
    push_job(3, 2, 1);
    start_job(3, 2, 1'b0);
    wait_done(1'b0, 60, n, ok);
    step(1'b0);
    checks++;
    if (!ok || n != 12) begin
      errors++; $display("FAIL midrst_latency: got ok=%b n=%0d, want ok=1 n=12", ok, n);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL midrst_cmd: got none, want %h", e);
      end else begin
        g = obs_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL midrst_cmd: got %h, want %h", g, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0 || out_cnt !== 16'd2) begin
      errors++; $display("FAIL midrst_status: got extra=%0d cnt=%0d, want 0 2", obs_q.size(), out_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_zero_len();
    test_abort();
    test_start_while_busy();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/acc_seq.md
Name: acc_seq

Overview:
Sequencer that drives the accumulator/output stage's 3-bit command and data inputs for one convolution job.
- Accepts a job config: partial sums per output, outputs per job.
- Pulls partial sums from the upstream MAC array over a valid/ready stream.
- Frames the whole job as one concatenation burst: concat-start, then per output (acc × N, output), then concat-end.
- Reports busy, done and aborted to the top-level controller.

Parameters:
DW, 32, data width of partial sums and data_o
CNT_W, 16, width of length/count fields

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
start  input  1  job start pulse; sampled only in IDLE
abort  input  1  synchronous job abort; ignored in IDLE
acc_len  input  CNT_W  partial sums per output; latched on accepted start
out_num  input  CNT_W  outputs per job; latched on accepted start
in_valid  input  1  upstream partial sum valid
in_data  input  DW  upstream partial sum
in_ready  output  1  combinational; high only in ACC
sig_o  output  3  command to accumulator stage (registered)
data_o  output  DW  data to accumulator stage (registered)
busy  output  1  high from the cycle after an accepted start until IDLE re-entered
done  output  1  one-cycle pulse at job end (normal or abort)
aborted  output  1  valid with done; 1 if the job ended by abort
out_cnt  output  CNT_W  outputs emitted in current/last job

Behaviour:
- Reset (rst=0, async): state=IDLE; sig_o=000, data_o=0, busy=0, done=0, aborted=0, out_cnt=0; latched config cleared.
- Command encoding:
  - 000 nop
  - 001 accumulate
  - 010 output
  - 011 concat start
  - 100 concat end
- sig_o is 000 in every cycle not listed below.
- sig_o/data_o are registered: a command decided in cycle t appears in cycle t+1. data_o holds its last value except on accumulate.
- IDLE:
  - start=1 latches acc_len and out_num, clears out_cnt and aborted.
  - If acc_len==0 or out_num==0 → DONE (no commands issued, done pulse, aborted=0).
  - Otherwise → CSTART.
- CSTART: issue 011 for one cycle → ACC with beat counter=0.
- ACC:
  - in_ready=1.
  - Each cycle with in_valid=1: issue 001, data_o<=in_data, beat++.
  - in_valid=0 stalls with no command.
  - On the acc_len-th beat → EMIT.
- EMIT: issue 010 for one cycle; out_cnt++.
  - If out_cnt+1 < out_num → ACC (beat=0).
  - Else → CEND.
- CEND: issue 100 for one cycle → DONE.
- DONE: done=1 for one cycle, busy=0 → IDLE. A start in this cycle is ignored.
- abort=1 in CSTART/ACC/EMIT:
  - The current cycle's command is suppressed, and no handshake completes (in_ready forced 0).
  - aborted<=1, then → CEND (concat end is still issued), then DONE.
- abort in CEND or DONE: no effect on the sequence, and aborted is not set.
- abort and start together in IDLE: start wins and abort is ignored.
- start while busy: ignored; latched config unchanged.
- Counters compare against latched values only; live acc_len/out_num changes mid-job have no effect.
- Max acc_len/out_num = 2^CNT_W−1. out_cnt never wraps within a job.
- Async reset mid-job: immediate return to reset values. No concat end is issued; the downstream stage is reset by the same rst.

Test Plan:
- Reset then start with acc_len=3, out_num=2, in_valid held 1, in_data=1,2,3,4,5,6 → sig_o sequence 011,001,001,001,010,001,001,001,010,100; data_o follows 1..6 on 001 cycles; done pulses once, out_cnt=2, aborted=0.
- Same config with in_valid toggled 1/0 every cycle → identical command order; 000 gaps where in_valid=0; in_ready high only in ACC.
- start with acc_len=0, out_num=5 → no non-000 sig_o; done pulses 2 cycles after start; out_cnt=0.
- acc_len=4, out_num=3, assert abort on the 2nd accumulate beat of output 1 → that beat is not issued and in_ready=0; next non-000 command is 100; done=1 with aborted=1; out_cnt=1.
- start pulsed again while busy with different acc_len → ignored; the job completes with the original config.
- Drop rst during ACC → sig_o=000, busy=0, in_ready=0 immediately; after release, a new start runs a full correct sequence.
